// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: arbiter state encoding, field widths and the
// request-field bundle used by the arbiter, the CPU interface and the
// SDRAM controller.
package sdram_pkg;

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_e;

    // Request fields that travel together with req_valid/req_ready.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic              we;
    } sd_req_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational 2-way picker: fixed priority to port 0 or round-robin.
// Ports:
//   valid  - request valid per port
//   rr_ptr - round-robin preferred port when both request
//   grant  - one-hot pick, 00 when nothing requests
module sdram_arb_pick #(
    parameter bit PRIO0 = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (PRIO0 || !rr_ptr) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sdram_arb.sv
// Two-port SDRAM arbiter. Port 0 is the CPU bus, port 1 the DMA/video fetch.
// One owner at a time: its request is forwarded to the controller and the
// write or read data stream stays locked to it until the last beat.
// Ports:
//   clk_i, rst_ni          - clock, async active-low reset
//   m0_*, m1_*             - requester request / write stream / read stream
//   sd_*                   - controller request / write stream / read stream
//   grant                  - one-hot current owner, 00 when idle
//   busy                   - arbiter not idle
module sdram_arb
    import sdram_pkg::*;
#(
    parameter bit PRIO0 = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [LEN_W-1:0]  m0_req_len,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic              m0_req_we,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic [MASK_W-1:0] m0_dout_mask,
    input  logic              m0_dout_valid,
    output logic              m0_dout_ready,
    output logic [DATA_W-1:0] m0_din,
    output logic              m0_din_valid,
    input  logic              m0_din_ready,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [LEN_W-1:0]  m1_req_len,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic              m1_req_we,
    input  logic [DATA_W-1:0] m1_dout,
    input  logic [MASK_W-1:0] m1_dout_mask,
    input  logic              m1_dout_valid,
    output logic              m1_dout_ready,
    output logic [DATA_W-1:0] m1_din,
    output logic              m1_din_valid,
    input  logic              m1_din_ready,

    output logic              sd_req_valid,
    input  logic              sd_req_ready,
    output logic [LEN_W-1:0]  sd_req_len,
    output logic [ADDR_W-1:0] sd_req_addr,
    output logic              sd_req_we,
    output logic [DATA_W-1:0] sd_dout,
    output logic [MASK_W-1:0] sd_dout_mask,
    output logic              sd_dout_valid,
    input  logic              sd_dout_ready,
    input  logic [DATA_W-1:0] sd_din,
    input  logic              sd_din_valid,
    output logic              sd_din_ready,

    output logic [1:0]        grant,
    output logic              busy
);

    arb_state_e        state, state_nxt;
    logic              owner, owner_nxt;
    logic              rr_ptr, rr_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        pick;

    sd_req_t           m0_req, m1_req, own_req;
    logic              own_req_valid;
    logic [DATA_W-1:0] own_dout;
    logic [MASK_W-1:0] own_mask;
    logic              own_dout_valid;
    logic              own_din_ready;

    // Owner-side results, fanned out to the owning port only.
    logic              own_req_ready;
    logic              own_dout_ready;
    logic [DATA_W-1:0] own_din;
    logic              own_din_valid;

    assign m0_req = '{addr: m0_req_addr, len: m0_req_len, we: m0_req_we};
    assign m1_req = '{addr: m1_req_addr, len: m1_req_len, we: m1_req_we};

    // Owner-selected inputs; muxed purely from the owner register.
    assign own_req        = owner ? m1_req        : m0_req;
    assign own_req_valid  = owner ? m1_req_valid  : m0_req_valid;
    assign own_dout       = owner ? m1_dout       : m0_dout;
    assign own_mask       = owner ? m1_dout_mask  : m0_dout_mask;
    assign own_dout_valid = owner ? m1_dout_valid : m0_dout_valid;
    assign own_din_ready  = owner ? m1_din_ready  : m0_din_ready;

    sdram_arb_pick #(
        .PRIO0 (PRIO0)
    ) u_pick (
        .valid  ({m1_req_valid, m0_req_valid}),
        .rr_ptr (rr_ptr),
        .grant  (pick)
    );

    // State, owner, round-robin pointer and beat counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Next-state logic and owner/controller muxing.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rr_nxt         = rr_ptr;
        cnt_nxt        = cnt;

        own_req_ready  = 1'b0;
        own_dout_ready = 1'b0;
        own_din        = '0;
        own_din_valid  = 1'b0;

        sd_req_valid   = 1'b0;
        sd_req_len     = '0;
        sd_req_addr    = '0;
        sd_req_we      = 1'b0;
        sd_dout        = '0;
        sd_dout_mask   = '0;
        sd_dout_valid  = 1'b0;
        sd_din_ready   = 1'b0;

        case (state)
            IDLE: begin
                if (|pick) begin
                    owner_nxt = pick[1];
                    state_nxt = REQ;
                end
            end
            REQ: begin
                sd_req_valid  = own_req_valid;
                sd_req_len    = own_req.len;
                sd_req_addr   = own_req.addr;
                sd_req_we     = own_req.we;
                own_req_ready = sd_req_ready;
                if (own_req_valid && sd_req_ready) begin
                    cnt_nxt   = own_req.len;
                    state_nxt = own_req.we ? WDATA : RDATA;
                end
            end
            WDATA: begin
                sd_dout        = own_dout;
                sd_dout_mask   = own_mask;
                sd_dout_valid  = own_dout_valid;
                own_dout_ready = sd_dout_ready;
                if (own_dout_valid && sd_dout_ready) begin
                    // len=0 loads 0 and wraps through 15..1: 16 beats.
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nxt = IDLE;
                        rr_nxt    = ~owner;
                    end
                end
            end
            RDATA: begin
                own_din       = sd_din;
                own_din_valid = sd_din_valid;
                sd_din_ready  = own_din_ready;
                if (sd_din_valid && own_din_ready) begin
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nxt = IDLE;
                        rr_nxt    = ~owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        m0_req_ready  = !owner && own_req_ready;
        m1_req_ready  =  owner && own_req_ready;
        m0_dout_ready = !owner && own_dout_ready;
        m1_dout_ready =  owner && own_dout_ready;
        m0_din_valid  = !owner && own_din_valid;
        m1_din_valid  =  owner && own_din_valid;
        m0_din        = owner ? '0 : own_din;
        m1_din        = owner ? own_din : '0;
    end

    assign busy  = (state != IDLE);
    assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: a round-robin instance (dut) and a fixed
// priority instance (dut_p) share all inputs; outputs are checked against
// hand-computed values.
module tb_sdram_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    logic        m0_req_valid, m0_req_we, m0_dout_valid, m0_din_ready;
    logic [3:0]  m0_req_len, m0_dout_mask;
    logic [31:0] m0_req_addr, m0_dout;
    logic        m1_req_valid, m1_req_we, m1_dout_valid, m1_din_ready;
    logic [3:0]  m1_req_len, m1_dout_mask;
    logic [31:0] m1_req_addr, m1_dout;
    logic        sd_req_ready, sd_dout_ready, sd_din_valid;
    logic [31:0] sd_din;

    // Outputs of the round-robin instance
    logic        m0_req_ready, m0_dout_ready, m0_din_valid;
    logic        m1_req_ready, m1_dout_ready, m1_din_valid;
    logic [31:0] m0_din, m1_din;
    logic        sd_req_valid, sd_req_we, sd_dout_valid, sd_din_ready;
    logic [3:0]  sd_req_len, sd_dout_mask;
    logic [31:0] sd_req_addr, sd_dout;
    logic [1:0]  grant;
    logic        busy;

    // Outputs of the fixed-priority instance
    logic        p_m0_req_ready, p_m0_dout_ready, p_m0_din_valid;
    logic        p_m1_req_ready, p_m1_dout_ready, p_m1_din_valid;
    logic [31:0] p_m0_din, p_m1_din;
    logic        p_sd_req_valid, p_sd_req_we, p_sd_dout_valid, p_sd_din_ready;
    logic [3:0]  p_sd_req_len, p_sd_dout_mask;
    logic [31:0] p_sd_req_addr, p_sd_dout;
    logic [1:0]  p_grant;
    logic        p_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    sdram_arb #(.PRIO0(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_len(m0_req_len),
        .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we), .m0_dout(m0_dout),
        .m0_dout_mask(m0_dout_mask), .m0_dout_valid(m0_dout_valid), .m0_dout_ready(m0_dout_ready),
        .m0_din(m0_din), .m0_din_valid(m0_din_valid), .m0_din_ready(m0_din_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_len(m1_req_len),
        .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we), .m1_dout(m1_dout),
        .m1_dout_mask(m1_dout_mask), .m1_dout_valid(m1_dout_valid), .m1_dout_ready(m1_dout_ready),
        .m1_din(m1_din), .m1_din_valid(m1_din_valid), .m1_din_ready(m1_din_ready),
        .sd_req_valid(sd_req_valid), .sd_req_ready(sd_req_ready), .sd_req_len(sd_req_len),
        .sd_req_addr(sd_req_addr), .sd_req_we(sd_req_we), .sd_dout(sd_dout),
        .sd_dout_mask(sd_dout_mask), .sd_dout_valid(sd_dout_valid), .sd_dout_ready(sd_dout_ready),
        .sd_din(sd_din), .sd_din_valid(sd_din_valid), .sd_din_ready(sd_din_ready),
        .grant(grant), .busy(busy)
    );

    sdram_arb #(.PRIO0(1'b1)) dut_p (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_valid(m0_req_valid), .m0_req_ready(p_m0_req_ready), .m0_req_len(m0_req_len),
        .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we), .m0_dout(m0_dout),
        .m0_dout_mask(m0_dout_mask), .m0_dout_valid(m0_dout_valid), .m0_dout_ready(p_m0_dout_ready),
        .m0_din(p_m0_din), .m0_din_valid(p_m0_din_valid), .m0_din_ready(m0_din_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(p_m1_req_ready), .m1_req_len(m1_req_len),
        .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we), .m1_dout(m1_dout),
        .m1_dout_mask(m1_dout_mask), .m1_dout_valid(m1_dout_valid), .m1_dout_ready(p_m1_dout_ready),
        .m1_din(p_m1_din), .m1_din_valid(p_m1_din_valid), .m1_din_ready(m1_din_ready),
        .sd_req_valid(p_sd_req_valid), .sd_req_ready(sd_req_ready), .sd_req_len(p_sd_req_len),
        .sd_req_addr(p_sd_req_addr), .sd_req_we(p_sd_req_we), .sd_dout(p_sd_dout),
        .sd_dout_mask(p_sd_dout_mask), .sd_dout_valid(p_sd_dout_valid), .sd_dout_ready(sd_dout_ready),
        .sd_din(sd_din), .sd_din_valid(sd_din_valid), .sd_din_ready(p_sd_din_ready),
        .grant(p_grant), .busy(p_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req_valid = 0; m0_req_we = 0; m0_req_len = 0; m0_req_addr = 0;
        m0_dout = 0; m0_dout_mask = 0; m0_dout_valid = 0; m0_din_ready = 0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_len = 0; m1_req_addr = 0;
        m1_dout = 0; m1_dout_mask = 0; m1_dout_valid = 0; m1_din_ready = 0;
        sd_req_ready = 0; sd_dout_ready = 0; sd_din_valid = 0; sd_din = 0;
    endtask

    logic [1:0] exp_g  [9];
    logic [1:0] exp_pg [9];
    int hs, b, k, r;

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        adv(); adv();
        #1;
        // ---- reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sd_req_valid", 32'(sd_req_valid), 0);
        chk("rst_sd_req_addr", sd_req_addr, 0);
        chk("rst_sd_dout_valid", 32'(sd_dout_valid), 0);
        rst_ni = 1'b1;
        adv();

        // ---- simultaneous pair, rr_ptr=0: m0 write then m1 read
        m0_req_valid = 1; m0_req_we = 1; m0_req_len = 1; m0_req_addr = 32'h200;
        m0_dout = 32'hDEADBEEF; m0_dout_mask = 4'hF; m0_dout_valid = 1;
        m1_req_valid = 1; m1_req_we = 0; m1_req_len = 1; m1_req_addr = 32'h300;
        sd_req_ready = 1; sd_dout_ready = 1;
        #1;
        chk("pair_idle_grant", 32'(grant), 0);
        adv(); #1;
        chk("pair_grant_m0", 32'(grant), 32'h1);
        chk("pair_addr_m0", sd_req_addr, 32'h200);
        chk("pair_we_m0", 32'(sd_req_we), 1);
        chk("pair_m0_ready", 32'(m0_req_ready), 1);
        chk("pair_m1_ready", 32'(m1_req_ready), 0);
        adv(); m0_req_valid = 0; #1;
        chk("pair_sd_dout", sd_dout, 32'hDEADBEEF);
        chk("pair_m0_dout_ready", 32'(m0_dout_ready), 1);
        chk("pair_m1_dout_ready", 32'(m1_dout_ready), 0);
        adv(); m0_dout_valid = 0; #1;
        chk("pair_idle_between", 32'(busy), 0);
        adv(); #1;
        chk("pair_grant_m1", 32'(grant), 32'h2);
        chk("pair_addr_m1", sd_req_addr, 32'h300);
        chk("pair_m1_req_ready", 32'(m1_req_ready), 1);
        adv(); m1_req_valid = 0; sd_req_ready = 0;
        sd_din = 32'h55; sd_din_valid = 1; m1_din_ready = 1; #1;
        chk("pair_m1_din", m1_din, 32'h55);
        chk("pair_m1_din_valid", 32'(m1_din_valid), 1);
        chk("pair_m0_din_valid", 32'(m0_din_valid), 0);
        adv(); clear_inputs(); #1;
        chk("pair_end_busy", 32'(busy), 0);

        // ---- single port-0 read, len=4 (leaves rr_ptr=1)
        m0_req_valid = 1; m0_req_we = 0; m0_req_len = 4; m0_req_addr = 32'h100;
        adv(); #1;
        chk("rd_addr", sd_req_addr, 32'h100);
        chk("rd_len", 32'(sd_req_len), 4);
        chk("rd_valid", 32'(sd_req_valid), 1);
        chk("rd_ready_stall", 32'(m0_req_ready), 0);
        sd_req_ready = 1; #1;
        chk("rd_ready", 32'(m0_req_ready), 1);
        adv(); m0_req_valid = 0; sd_req_ready = 0; m0_din_ready = 1;
        for (int i = 0; i < 4; i++) begin
            sd_din = 32'hA0 + 32'(i); sd_din_valid = 1; #1;
            chk("rd_beat", m0_din, 32'hA0 + 32'(i));
            chk("rd_m0_valid", 32'(m0_din_valid), 1);
            chk("rd_m1_valid", 32'(m1_din_valid), 0);
            chk("rd_busy", 32'(busy), 1);
            adv();
        end
        sd_din_valid = 0; #1;
        chk("rd_done_busy", 32'(busy), 0);
        chk("rd_done_grant", 32'(grant), 0);
        clear_inputs();

        // ---- both ports requesting continuously: rr alternates, prio keeps m0
        exp_g  = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        exp_pg = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        m0_req_valid = 1; m0_req_we = 1; m0_req_len = 1; m0_req_addr = 32'h400;
        m0_dout_valid = 1; m0_dout = 32'h1234; m0_dout_mask = 4'hF;
        m1_req_valid = 1; m1_req_we = 0; m1_req_len = 1; m1_req_addr = 32'h500;
        m1_din_ready = 1; sd_req_ready = 1; sd_dout_ready = 1; sd_din_valid = 1;
        for (int i = 0; i < 9; i++) begin
            adv(); #1;
            chk("cont_rr_grant", 32'(grant), 32'(exp_g[i]));
            chk("cont_prio_grant", 32'(p_grant), 32'(exp_pg[i]));
            chk("cont_prio_m1_ready", 32'(p_m1_req_ready), 0);
        end
        clear_inputs();

        // ---- write len=0 from m1: 16 beats, 17th refused
        m1_req_valid = 1; m1_req_we = 1; m1_req_len = 0; m1_req_addr = 32'h1000;
        sd_req_ready = 1;
        adv(); #1;
        chk("w16_grant", 32'(grant), 32'h2);
        chk("w16_len", 32'(sd_req_len), 0);
        adv(); m1_req_valid = 0; sd_req_ready = 0;
        m1_dout_valid = 1; m1_dout_mask = 4'hF; sd_dout_ready = 1;
        hs = 0;
        for (int i = 0; i < 16; i++) begin
            m1_dout = 32'h1000 + 32'(i); #1;
            chk("w16_data", sd_dout, 32'h1000 + 32'(i));
            chk("w16_mask", 32'(sd_dout_mask), 32'hF);
            if (sd_dout_valid && sd_dout_ready) hs++;
            adv();
        end
        m1_dout = 32'h2000; #1;
        chk("w16_extra_ready", 32'(m1_dout_ready), 0);
        chk("w16_extra_sd_valid", 32'(sd_dout_valid), 0);
        chk("w16_hs", 32'(hs), 16);
        chk("w16_idle", 32'(busy), 0);
        clear_inputs();

        // ---- backpressure: request stall, then toggling data readies
        m0_req_valid = 1; m0_req_we = 1; m0_req_len = 3; m0_req_addr = 32'h2000;
        adv();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_addr", sd_req_addr, 32'h2000);
            chk("bp_len", 32'(sd_req_len), 3);
            chk("bp_no_ready", 32'(m0_req_ready), 0);
            adv();
        end
        sd_req_ready = 1; #1;
        chk("bp_ready", 32'(m0_req_ready), 1);
        adv(); m0_req_valid = 0; sd_req_ready = 0;
        b = 0; hs = 0;
        for (int i = 0; i < 20 && b < 3; i++) begin
            m0_dout = 32'hB0 + 32'(b); m0_dout_valid = 1; m0_dout_mask = 4'h5;
            sd_dout_ready = i[0]; #1;
            chk("bp_wdata", sd_dout, 32'hB0 + 32'(b));
            chk("bp_wrdy", 32'(m0_dout_ready), 32'(sd_dout_ready));
            if (sd_dout_valid && sd_dout_ready) hs++;
            if (m0_dout_ready) b++;
            adv();
        end
        m0_dout_valid = 0; sd_dout_ready = 0; #1;
        chk("bp_wbeats", 32'(b), 3);
        chk("bp_whs", 32'(hs), 3);
        chk("bp_widle", 32'(busy), 0);

        m0_req_valid = 1; m0_req_we = 0; m0_req_len = 3; m0_req_addr = 32'h3000;
        sd_req_ready = 1;
        adv(); #1;
        chk("bp_rgrant", 32'(grant), 32'h1);
        adv(); m0_req_valid = 0; sd_req_ready = 0;
        k = 0; r = 0;
        for (int i = 0; i < 20 && r < 3; i++) begin
            sd_din = 32'hC0 + 32'(k); sd_din_valid = (k < 3); m0_din_ready = i[0]; #1;
            chk("bp_rrdy", 32'(sd_din_ready), 32'(m0_din_ready));
            if (m0_din_valid && m0_din_ready) begin
                chk("bp_rdata", m0_din, 32'hC0 + 32'(r));
                r++;
            end
            if (sd_din_valid && sd_din_ready) k++;
            adv();
        end
        clear_inputs(); #1;
        chk("bp_rbeats", 32'(r), 3);
        chk("bp_rk", 32'(k), 3);
        chk("bp_ridle", 32'(busy), 0);

        // ---- async reset mid-RDATA after beat 2 of 4 (rr_ptr is 1 here)
        m0_req_valid = 1; m0_req_we = 0; m0_req_len = 4; m0_req_addr = 32'h4000;
        sd_req_ready = 1;
        adv(); adv();
        m0_req_valid = 0; sd_req_ready = 0; sd_din_valid = 1; m0_din_ready = 1;
        for (int i = 0; i < 2; i++) begin
            sd_din = 32'hE0 + 32'(i); #1;
            chk("rst_mid_beat", m0_din, 32'hE0 + 32'(i));
            adv();
        end
        #1;
        chk("rst_mid_pre_busy", 32'(busy), 1);
        rst_ni = 1'b0; #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_din_valid", 32'(m0_din_valid), 0);
        chk("rst_mid_sd_din_ready", 32'(sd_din_ready), 0);
        chk("rst_mid_sd_req_valid", 32'(sd_req_valid), 0);
        chk("rst_mid_p_busy", 32'(p_busy), 0);
        clear_inputs();
        adv(); #2;
        rst_ni = 1'b1;
        adv();
        m0_req_valid = 1; m0_req_len = 1; m0_req_addr = 32'h10;
        m1_req_valid = 1; m1_req_len = 1; m1_req_addr = 32'h20;
        adv(); #1;
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_addr", sd_req_addr, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
